adc_mavg_filter: RTL and testbench
==================================

# adc_mavg_filter

- Moving-average filter between the serial ADC receiver and the PID controller.
- Takes each completed ADC word and its done-tick, which come from the slow serial-clock domain.
- Keeps a running sum over the last 2^LOG2_N samples and presents the truncated mean to the PID input register, together with a one-cycle valid strobe in the `clk` domain.
- Suppresses single-sample noise on the plant measurement `yk` before offset removal and PID.

## Interface

- `DATA_W`, 11: ADC word width (unsigned, midscale = 2^(DATA_W-1)).
- `LOG2_N`, 3: log2 of the averaging window; N = 2^LOG2_N, legal range 1..4.
- `clk`  in  1  system clock; all state is clocked on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `din`  in  DATA_W  ADC sample. It is held stable by the source for at least 3 `clk` cycles after `din_valid` rises.
- `din_valid`  in  1  done-tick from the ADC receiver. It is asynchronous to `clk` and only its rising edge is significant.
- `flush`  in  1  synchronous window clear, active-high, one cycle.
- `dout`  out  DATA_W  filtered sample.
- `dout_valid`  out  1  one-cycle strobe: `dout` was updated this cycle.
- `primed`  out  1  high once N real samples have entered the window since reset or flush.

## Operation

- Input capture:
  - 2-flop synchronizer on `din_valid`, then a third flop for edge detection.
  - `take = s1 & ~s2`.
  - A level held high produces exactly one `take`.
- Storage:
  - N-entry register array `buf`, write pointer `wr_ptr` (LOG2_N bits), running sum `acc` (DATA_W+LOG2_N bits, unsigned).
  - Fill counter `cnt` saturating at N.
- On `take`:
  - `acc <= acc + din - buf[wr_ptr]`.
  - `buf[wr_ptr] <= din`.
  - `wr_ptr <= wr_ptr + 1`, wrapping N-1 → 0.
  - `cnt` increments unless already N.
- Output stage, one cycle after `take`:
  - `dout <= acc[DATA_W+LOG2_N-1:LOG2_N]` (truncate, no rounding).
  - `dout_valid <= 1`.
- Arithmetic:
  - `acc` never exceeds N·(2^DATA_W−1), so no overflow or wrap.
  - The subtraction is done at full `acc` width and cannot underflow, because `buf[wr_ptr]` is always part of `acc`.
- Warm-up:
  - All `buf` entries are preloaded with midscale, so early outputs pull from midscale rather than zero.
  - `primed` asserts in the same cycle as the `dout_valid` of the Nth sample.
- `flush`:
  - Same effect as reset on `buf`, `acc`, `wr_ptr`, `cnt`, `primed`, `dout`.
  - Applied on the next `clk` edge. Synchronizer flops are not cleared.
- Simultaneous `flush` and `take`:
  - `flush` wins and the sample is dropped.
  - If a `take` was in the output stage, its `dout_valid` is suppressed.

## Timing

- Reset values:
  - `dout` = 2^(DATA_W-1) (0x400 at default width).
  - `dout_valid` = 0, `primed` = 0.
  - `buf[*]` = midscale, `acc` = N·midscale, `wr_ptr` = 0, `cnt` = 0, synchronizer flops 0.
- Latency, with `din_valid` rising and first sampled at edge k:
  - `take` is true in the cycle after edge k+1.
  - `acc`/`buf` update at edge k+2.
  - `dout`/`dout_valid` register at edge k+3.
  - `dout_valid` is high for exactly one cycle.
- `din` is sampled at edge k+2. The source's hold requirement (≥3 `clk` cycles) covers this.
- Minimum spacing between `din_valid` rising edges: 3 `clk` cycles (the synchronizer needs a low sample). Closer edges may be merged.
- Reset mid-window: everything returns to reset values immediately. An in-flight `dout_valid` is never emitted.
- `dout` holds its value between strobes.

## Configuration

- `ADC_MAVG_OFFSET_EN`, when defined:
  - `dout` is the two's-complement mean minus midscale, so midscale reads 0 and 0x600 reads +0x200.
  - Reset and flush value of `dout` is 0.
  - `dout` feeds the PID `yk` directly, without a separate subtractor.
- When undefined:
  - `dout` is the unsigned mean.
  - Reset value is midscale.
  - Width is DATA_W in both cases.

## Test plan

- Reset, no samples: `dout`=0x400, `dout_valid`=0, `primed`=0 held for 100 cycles. Pulse `din_valid` high for 10 cycles once → exactly one `dout_valid`.
- Eight samples of 0x600, 3 cycles after each rising edge:
  - `dout` sequence 0x440, 0x480, 0x4C0, 0x500, 0x540, 0x580, 0x5C0, 0x600.
  - `primed` rises with the 8th strobe.
  - Each strobe appears 3 edges after its `din_valid` rise.
- Wrap-around: 16 samples of 0x7FF → `dout`=0x7FF from the 8th strobe on, `acc`=0x3FF8 with no overflow. Then 8 samples of 0x000 → `dout` ends at 0x000.
- Flush mid-run:
  - After 5 samples of 0x600, pulse `flush` → `dout`=0x400, `primed`=0.
  - A `take` coinciding with `flush` yields no strobe.
- Async reset asserted one cycle after `take` → no `dout_valid`, all outputs at reset values.
- With `ADC_MAVG_OFFSET_EN`: reset `dout`=0. Eight samples of 0x600 → final `dout`=+0x200. Eight samples of 0x200 → −0x200 (0x600 as 11-bit two's complement).

Source files
------------

// File: rtl/adc_mavg_filter.sv
// Moving-average filter over the last 2^LOG2_N ADC samples, with the done-tick synchronised into clk.
// Optional define ADC_MAVG_OFFSET_EN: dout is the mean minus midscale (two's complement).
module adc_mavg_filter #(
    parameter int DATA_W = 11,
    parameter int LOG2_N = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              flush,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              primed
);
    localparam int N     = 1 << LOG2_N;
    localparam int ACC_W = DATA_W + LOG2_N;
    localparam logic [DATA_W-1:0] MID     = {1'b1, {(DATA_W-1){1'b0}}};
    // N * midscale is exactly the top bit of the accumulator
    localparam logic [ACC_W-1:0]  ACC_RST = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [LOG2_N:0]   CNT_FULL = (LOG2_N+1)'(N);
`ifdef ADC_MAVG_OFFSET_EN
    localparam logic [DATA_W-1:0] DOUT_RST = '0;
`else
    localparam logic [DATA_W-1:0] DOUT_RST = MID;
`endif

    logic [2:0]                   sync;
    logic                         take;
    logic [N-1:0][DATA_W-1:0]     win;
    logic [LOG2_N-1:0]            wr_ptr;
    logic [LOG2_N:0]              cnt;
    logic [ACC_W-1:0]             acc;
    logic [2:1]                   vld_pipe;
    logic [DATA_W-1:0]            mean;

    assign take       = sync[1] & ~sync[2];
    assign mean       = acc[ACC_W-1:LOG2_N];
    assign dout_valid = vld_pipe[2];

    // Synchroniser is deliberately left out of flush so a pending edge is not re-detected
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= '0;
        else     sync <= {sync[1:0], din_valid};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win      <= {N{MID}};
            acc      <= ACC_RST;
            wr_ptr   <= '0;
            cnt      <= '0;
            primed   <= 1'b0;
            dout     <= DOUT_RST;
            vld_pipe <= '0;
        end else if (flush) begin
            win      <= {N{MID}};
            acc      <= ACC_RST;
            wr_ptr   <= '0;
            cnt      <= '0;
            primed   <= 1'b0;
            dout     <= DOUT_RST;
            vld_pipe <= '0;
        end else begin
            if (take) begin
                // The evicted entry is always part of acc, so this cannot underflow
                acc         <= acc + ACC_W'(din) - ACC_W'(win[wr_ptr]);
                win[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
                if (cnt != CNT_FULL) cnt <= cnt + 1'b1;
            end
            vld_pipe <= {vld_pipe[1], take};
            primed   <= (cnt == CNT_FULL);
            if (vld_pipe[1]) begin
`ifdef ADC_MAVG_OFFSET_EN
                dout <= mean - MID;
`else
                dout <= mean;
`endif
            end
        end
    end
endmodule

// File: tb/tb_adc_mavg_filter.sv
// Scoreboard bench for adc_mavg_filter: expected means come from a sample history padded with midscale.
module tb_adc_mavg_filter;
    localparam int DATA_W = 11;
    localparam int LOG2_N = 3;
    localparam int N      = 8;
    localparam logic [10:0] MID = 11'h400;
`ifdef ADC_MAVG_OFFSET_EN
    localparam logic [10:0] EXP_RST = 11'h000;
`else
    localparam logic [10:0] EXP_RST = 11'h400;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] din = '0;
    logic              din_valid = 1'b0;
    logic              flush = 1'b0;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              primed;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [10:0] dout;
        logic        primed;
    } exp_t;

    exp_t        sb[$];
    logic [10:0] hist[$];

    adc_mavg_filter #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .flush(flush),
        .dout(dout), .dout_valid(dout_valid), .primed(primed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Mean of the last N samples, with missing history standing in as midscale
    function automatic exp_t model_push(input logic [10:0] v);
        exp_t e;
        int   sum;
        logic [10:0] mean;
        hist.push_back(v);
        if (hist.size() > N) void'(hist.pop_front());
        sum = (N - hist.size()) * int'(MID);
        foreach (hist[i]) sum += int'(hist[i]);
        mean = 11'(sum / N);
`ifdef ADC_MAVG_OFFSET_EN
        e.dout = mean - MID;
`else
        e.dout = mean;
`endif
        e.primed = (hist.size() == N);
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && dout_valid) begin
            if (sb.size() == 0) begin
                check("spurious_strobe", dout_valid, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("dout", dout, e.dout);
                check("primed", primed, e.primed);
            end
        end
    end

    // One sample; the strobe must appear exactly 3 edges after the rise
    task automatic send(input logic [10:0] v, input int hold);
        @(negedge clk);
        din = v;
        din_valid = 1'b1;
        sb.push_back(model_push(v));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("lat_early", dout_valid, 1'b0);
        end
        @(posedge clk); #1;
        check("lat_k3", dout_valid, 1'b1);
        for (int i = 4; i < hold; i++) @(posedge clk);
        @(negedge clk);
        din_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        hist.delete();
        check("flush_dout", dout, EXP_RST);
        check("flush_primed", primed, 1'b0);
    endtask

    // Flush landing on the take edge (2) or while the take is in the output stage (3)
    task automatic send_flush(input logic [10:0] v, input int flush_at);
        @(negedge clk);
        din = v;
        din_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        if (flush_at == 3) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        hist.delete();
        check("fl_take_dout", dout, EXP_RST);
        check("fl_take_primed", primed, 1'b0);
        repeat (3) @(negedge clk);
        din_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("fl_take_nostrobe", dout_valid, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            repeat (10) @(negedge clk);
            check("idle_dout", dout, EXP_RST);
            check("idle_valid", dout_valid, 1'b0);
            check("idle_primed", primed, 1'b0);
        end

        // Long level: exactly one strobe
        send(11'h600, 10);
        repeat (5) @(negedge clk);
        do_flush();

        // Warm-up from midscale to 0x600
        for (int i = 0; i < N; i++) send(11'h600, 4);
        do_flush();

        // Flush mid-run
        for (int i = 0; i < 5; i++) send(11'h600, 4);
        do_flush();
        send_flush(11'h7FF, 2);
        send(11'h200, 4);
        send_flush(11'h7FF, 3);

        // Full-scale saturation of the window, then drain to zero
        do_flush();
        for (int i = 0; i < 2*N; i++) send(11'h7FF, 4);
        check("acc_full", dut.acc, 14'h3FF8);
        for (int i = 0; i < N; i++) send(11'h000, 4);
        for (int i = 0; i < N; i++) send(11'h200, 4);

        // Async reset one cycle after the take
        @(negedge clk);
        din = 11'h123;
        din_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_dout", dout, EXP_RST);
        check("rst_valid", dout_valid, 1'b0);
        check("rst_primed", primed, 1'b0);
        din_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hist.delete();
        repeat (5) @(negedge clk);
        check("post_rst_valid", dout_valid, 1'b0);
        check("post_rst_dout", dout, EXP_RST);
        send(11'h600, 4);

        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
